// File: rtl/piggy_uart_rx.sv
// UART receiver (8N1, LSB first) and decoder for the piggy bank's 4-byte total-report frame.
// Optional even-parity framing is enabled by defining PIGGY_RX_PARITY_EN.
module piggy_uart_rx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          TIMEOUT_BITS = 32,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic [15:0] total,
    output logic        total_valid,
    output logic        frame_err,
    output logic        chk_err,
    output logic        timeout_err,
    output logic        parity_err,
    output logic        busy
);

    localparam int HALF_BIT   = CLKS_PER_BIT / 2;
    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int TO_CYCLES  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W       = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} byte_state_t;
    typedef enum logic [1:0] {P_HUNT, P_LO, P_HI, P_CHK} parse_state_t;

    byte_state_t  bstate;
    parse_state_t pstate;

    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       lo, hi;
    logic [TO_W-1:0]  to_cnt;
    logic             fall;
    logic             bit_done;
    logic             to_hit;

    // Synchroniser resets to the idle line level so reset release cannot fake a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall     = (bstate == B_IDLE) && rx_prev && !rx_sync;
    assign bit_done = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

`ifdef PIGGY_RX_PARITY_EN
    logic par_bad;
`endif

    // Byte FSM: every strobe is registered, so it appears the cycle after the deciding sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate     <= B_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PIGGY_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout sequential blocks so every
            // register samples the pre-edge values, independent of statement order.
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef PIGGY_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (bstate)
                B_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (fall) bstate <= B_START;
                end
                B_START: begin
                    if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
                        clk_cnt <= '0;
                        bstate  <= rx_sync ? B_IDLE : B_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                B_DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef PIGGY_RX_PARITY_EN
                            bstate <= B_PARITY;
`else
                            bstate <= B_STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`ifdef PIGGY_RX_PARITY_EN
                B_PARITY: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        par_bad <= (^shift) ^ rx_sync;
                        bstate  <= B_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`endif
                B_STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        bstate  <= B_IDLE;
                        if (!rx_sync) begin
                            frame_err <= 1'b1;
                        end
`ifdef PIGGY_RX_PARITY_EN
                        else if (par_bad) begin
                            parity_err <= 1'b1;
                        end
`endif
                        else begin
                            byte_data  <= shift;
                            byte_valid <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end

`ifndef PIGGY_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Timeout only runs while a frame is open and the line is quiet between bytes.
    assign to_hit = (pstate != P_HUNT) && (bstate == B_IDLE) && !fall &&
                    (to_cnt == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate      <= P_HUNT;
            lo          <= '0;
            hi          <= '0;
            total       <= '0;
            total_valid <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
        end else begin
            total_valid <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;

            if (pstate == P_HUNT || bstate != B_IDLE || fall || byte_valid)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);

            // Line errors win over a coincident timeout, keeping one error strobe per cycle.
            if (frame_err || parity_err) begin
                pstate <= P_HUNT;
            end else if (byte_valid) begin
                case (pstate)
                    P_HUNT: if (byte_data == HEADER) pstate <= P_LO;
                    P_LO: begin
                        lo     <= byte_data;
                        pstate <= P_HI;
                    end
                    P_HI: begin
                        hi     <= byte_data;
                        pstate <= P_CHK;
                    end
                    P_CHK: begin
                        pstate <= P_HUNT;
                        if (byte_data == (HEADER ^ lo ^ hi)) begin
                            total       <= {hi, lo};
                            total_valid <= 1'b1;
                        end else begin
                            chk_err <= 1'b1;
                        end
                    end
                    default: pstate <= P_HUNT;
                endcase
            end else if (to_hit) begin
                timeout_err <= 1'b1;
                pstate      <= P_HUNT;
            end
        end
    end

    assign busy = (bstate != B_IDLE) || (pstate != P_HUNT);

endmodule

// File: tb/tb_piggy_uart_rx.sv
// Scoreboard bench for piggy_uart_rx: expected bytes/totals are queued as frames are sent
// and popped when the receiver pulses; error strobes are counted per scenario.
module tb_piggy_uart_rx;

    localparam int         CPB    = 16;
    localparam logic [7:0] HEADER = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [15:0] total;
    logic        total_valid;
    logic        frame_err;
    logic        chk_err;
    logic        timeout_err;
    logic        parity_err;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_frame  = 0;
    int n_chk    = 0;
    int n_to     = 0;
    int n_par    = 0;

    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_totals[$];

    piggy_uart_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(32), .HEADER(HEADER)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .total       (total),
        .total_valid (total_valid),
        .frame_err   (frame_err),
        .chk_err     (chk_err),
        .timeout_err (timeout_err),
        .parity_err  (parity_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        n_frame = 0;
        n_chk   = 0;
        n_to    = 0;
        n_par   = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(CPB);
        end
`ifdef PIGGY_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        wait_clks(CPB);
`endif
        rx = stop_bit;
        wait_clks(CPB);
        rx = 1'b1;
        wait_clks(4);
    endtask

    // Queues the four bytes and, if the bench's own checksum agrees, the resulting total.
    task automatic send_frame(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] chk);
        logic [7:0] f[4];
        f = '{HEADER, lo, hi, chk};
        if (chk == (HEADER ^ lo ^ hi)) exp_totals.push_back({hi, lo});
        for (int i = 0; i < 4; i++) begin
            exp_bytes.push_back(f[i]);
            send_byte(f[i], 1'b1, 1'b0);
        end
    endtask

    task automatic drain_check(input string tag);
        wait_clks(4 * CPB);
        check({tag, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
        check({tag, "_totals_left"}, 32'(exp_totals.size()), 32'd0);
    endtask

    // Monitor: compare every output pulse against the scoreboard and count error strobes.
    initial begin
        forever begin
            @(negedge clk);
            if (byte_valid) begin
                if (exp_bytes.size() == 0) check("byte_unexpected", 32'(byte_data), 32'hFFFF_FFFF);
                else check("byte_data", 32'(byte_data), 32'(exp_bytes.pop_front()));
            end
            if (total_valid) begin
                if (exp_totals.size() == 0) check("total_unexpected", 32'(total), 32'hFFFF_FFFF);
                else check("total", 32'(total), 32'(exp_totals.pop_front()));
            end
            if (frame_err)   n_frame++;
            if (chk_err)     n_chk++;
            if (timeout_err) n_to++;
            if (parity_err)  n_par++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        wait_clks(3);
        check("rst_byte_data", 32'(byte_data), 32'd0);
        check("rst_total", 32'(total), 32'd0);
        check("rst_strobes", 32'({byte_valid, total_valid, frame_err, chk_err, timeout_err, parity_err}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_clks(4);

        // Good frame
        clear_counts();
        send_frame(8'h34, 8'h12, 8'h83);
        drain_check("good");
        check("good_total_hold", 32'(total), 32'h1234);
        check("good_errs", 32'(n_frame + n_chk + n_to + n_par), 32'd0);
        check("good_busy", 32'(busy), 32'd0);

        // Checksum mismatch
        clear_counts();
        send_frame(8'h34, 8'h12, 8'h84);
        drain_check("chk");
        check("chk_err_count", 32'(n_chk), 32'd1);
        check("chk_total_kept", 32'(total), 32'h1234);
        check("chk_busy", 32'(busy), 32'd0);

        // Stop bit low on second byte, then a clean frame
        clear_counts();
        exp_bytes.push_back(HEADER);
        send_byte(HEADER, 1'b1, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        wait_clks(2 * CPB);
        check("frame_err_count", 32'(n_frame), 32'd1);
        check("frame_busy_hunt", 32'(busy), 32'd0);
        send_frame(8'h0A, 8'h00, 8'hAF);
        drain_check("frame");
        check("frame_total", 32'(total), 32'h000A);
        check("frame_other_errs", 32'(n_chk + n_to + n_par), 32'd0);

        // Start-bit glitch
        clear_counts();
        rx = 1'b0;
        wait_clks(CPB / 4);
        rx = 1'b1;
        wait_clks(3 * CPB);
        drain_check("glitch");
        check("glitch_errs", 32'(n_frame + n_chk + n_to + n_par), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);

        // Inter-byte timeout, then recovery
        clear_counts();
        exp_bytes.push_back(HEADER);
        send_byte(HEADER, 1'b1, 1'b0);
        exp_bytes.push_back(8'h34);
        send_byte(8'h34, 1'b1, 1'b0);
        wait_clks(30 * CPB);
        check("to_not_yet", 32'(n_to), 32'd0);
        check("to_busy_open", 32'(busy), 32'd1);
        wait_clks(3 * CPB);
        check("to_count", 32'(n_to), 32'd1);
        check("to_busy_hunt", 32'(busy), 32'd0);
        send_frame(8'h34, 8'h12, 8'h83);
        drain_check("to");
        check("to_total", 32'(total), 32'h1234);
        check("to_other_errs", 32'(n_frame + n_chk + n_par), 32'd0);

        // Reset mid-DATA of the HI byte
        clear_counts();
        exp_bytes.push_back(HEADER);
        send_byte(HEADER, 1'b1, 1'b0);
        exp_bytes.push_back(8'h34);
        send_byte(8'h34, 1'b1, 1'b0);
        rx = 1'b0;
        wait_clks(CPB);
        rx = 1'b0;
        wait_clks(CPB);
        rx = 1'b1;
        wait_clks(CPB / 2);
        rst_n = 1'b0;
        rx = 1'b1;
        wait_clks(2);
        check("mid_rst_total", 32'(total), 32'd0);
        check("mid_rst_byte", 32'(byte_data), 32'd0);
        check("mid_rst_outs", 32'({byte_valid, total_valid, frame_err, chk_err, timeout_err, parity_err, busy}), 32'd0);
        rst_n = 1'b1;
        wait_clks(4);
        send_frame(8'h01, 8'h00, 8'hA4);
        drain_check("post_rst");
        check("post_rst_total", 32'(total), 32'h0001);
        check("post_rst_errs", 32'(n_frame + n_chk + n_to + n_par), 32'd0);

`ifdef PIGGY_RX_PARITY_EN
        // Wrong parity on the checksum byte
        clear_counts();
        exp_bytes.push_back(HEADER);
        send_byte(HEADER, 1'b1, 1'b0);
        exp_bytes.push_back(8'h34);
        send_byte(8'h34, 1'b1, 1'b0);
        exp_bytes.push_back(8'h12);
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h83, 1'b1, 1'b1);
        drain_check("par");
        check("par_count", 32'(n_par), 32'd1);
        check("par_total_kept", 32'(total), 32'h0001);
        check("par_busy_hunt", 32'(busy), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
